// File: rtl/wave_capture_ctrl.sv
// Captures a zero-crossing-aligned window of samples into the back bank of the wave RAM
// and swaps banks on the next frame boundary so the display only ever reads complete windows.
module wave_capture_ctrl #(
    parameter int SAMPLES = 256,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_sample,
    input  logic [15:0]       sample,
    input  logic              vsync,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [7:0]        wr_data,
    output logic              read_bank,
    output logic              capturing
);

    localparam int                TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(SAMPLES - 1);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;
    logic [TMO_W-1:0]  tmo_q,       tmo_d;
    logic              prev_msb_q,  prev_msb_d;
    logic              vsync_s_q,   vsync_s_d;
    logic              vsync_d_q,   vsync_d_d;
    logic              read_bank_q, read_bank_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W:0]   wr_addr_q,   wr_addr_d;
    logic [7:0]        wr_data_q,   wr_data_d;
    logic              capturing_q, capturing_d;

    logic rise;
    logic crossing;
    logic tmo_hit;
    logic do_write;
    logic [ADDR_W-1:0] write_idx;

    // Only the top byte of the sample reaches the RAM.
    logic unused_sample_lo;
    assign unused_sample_lo = ^sample[7:0];

    // vsync is registered once before edge detection, so the swap lands two cycles after vsync rises.
    assign rise     = vsync_s_q & ~vsync_d_q;
    assign crossing = prev_msb_q & ~sample[15];
    assign tmo_hit  = (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        read_bank_d = read_bank_q;
        vsync_s_d   = vsync;
        vsync_d_d   = vsync_s_q;
        prev_msb_d  = new_sample ? sample[15] : prev_msb_q;
        do_write    = 1'b0;
        write_idx   = idx_q;

        case (state_q)
            ST_ARMED: begin
                if (new_sample) begin
                    if (crossing || tmo_hit) begin
                        do_write  = 1'b1;
                        write_idx = '0;
                        idx_d     = ADDR_W'(1);
                        tmo_d     = '0;
                        state_d   = ST_CAPTURE;
                    end else if (!tmo_hit) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            ST_CAPTURE: begin
                // A frame boundary here is dropped on purpose: the window is not complete yet.
                if (new_sample) begin
                    do_write = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (rise) begin
                    read_bank_d = ~read_bank_q;
                    tmo_d       = '0;
                    state_d     = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_ARMED;
            end
        endcase

        wr_en_d   = do_write;
        wr_addr_d = do_write ? {~read_bank_q, write_idx} : wr_addr_q;
        wr_data_d = do_write ? {~sample[15], sample[14:8]} : wr_data_q;
        capturing_d = (state_d == ST_CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ARMED;
            idx_q       <= '0;
            tmo_q       <= '0;
            prev_msb_q  <= 1'b0;
            vsync_s_q   <= 1'b0;
            vsync_d_q   <= 1'b0;
            read_bank_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            capturing_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            prev_msb_q  <= prev_msb_d;
            vsync_s_q   <= vsync_s_d;
            vsync_d_q   <= vsync_d_d;
            read_bank_q <= read_bank_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            capturing_q <= capturing_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign read_bank = read_bank_q;
    assign capturing = capturing_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Self-checking bench for wave_capture_ctrl: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_wave_capture_ctrl;

    localparam int SAMPLES = 256;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 1024;

    logic        clk;
    logic        reset;
    logic        new_sample;
    logic [15:0] sample;
    logic        vsync;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        read_bank;
    logic        capturing;

    int checks   = 0;
    int failures = 0;

    wave_capture_ctrl #(.SAMPLES(SAMPLES), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .new_sample (new_sample),
        .sample     (sample),
        .vsync      (vsync),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .read_bank  (read_bank),
        .capturing  (capturing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 = waiting for trigger, 1 = filling window, 2 = window full.
    int       m_mode = 0;
    int       m_idx  = 0;
    int       m_tmo  = 0;
    bit       m_prev = 0;
    bit       m_rb   = 0;
    bit       m_v1   = 0;
    bit       m_v2   = 0;
    bit       e_wr_en = 0;
    bit [8:0] e_addr  = 0;
    bit [7:0] e_data  = 0;
    bit       e_cap   = 0;

    function automatic void model_step(bit rst, bit ns, logic [15:0] s, bit vs);
        bit rise;
        if (rst) begin
            m_mode = 0; m_idx = 0; m_tmo = 0; m_prev = 0; m_rb = 0;
            m_v1 = 0; m_v2 = 0; e_wr_en = 0; e_addr = 0; e_data = 0; e_cap = 0;
            return;
        end
        rise = m_v1 && !m_v2;
        m_v2 = m_v1;
        m_v1 = vs;
        e_wr_en = 0;
        if (ns && m_mode == 0) begin
            if ((m_prev && !s[15]) || m_tmo == TIMEOUT - 1) begin
                e_wr_en = 1; e_addr = {!m_rb, 8'h00}; e_data = {!s[15], s[14:8]};
                m_idx = 1; m_tmo = 0; m_mode = 1;
            end else if (m_tmo < TIMEOUT - 1) begin
                m_tmo++;
            end
        end else if (ns && m_mode == 1) begin
            e_wr_en = 1; e_addr = {!m_rb, 8'(m_idx)}; e_data = {!s[15], s[14:8]};
            if (m_idx == SAMPLES - 1) begin
                m_mode = 2; m_idx = 0;
            end else begin
                m_idx++;
            end
        end else if (m_mode == 2 && rise) begin
            m_rb = !m_rb; m_tmo = 0; m_mode = 0;
        end
        if (ns) m_prev = s[15];
        e_cap = (m_mode == 1);
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, settle before sampling.
    task automatic cyc(input bit rst, input bit ns, input logic [15:0] s, input bit vs);
        reset = rst; new_sample = ns; sample = s; vsync = vs;
        @(posedge clk);
        model_step(rst, ns, s, vs);
        #1;
    endtask

    task automatic do_reset();
        cyc(1, 0, 16'h0, 0);
        cyc(1, 0, 16'h0, 0);
        cyc(0, 0, 16'h0, 0);
    endtask

    // Trigger with a -1 -> +1 crossing and fill a whole window with vsync held low.
    task automatic run_window();
        cyc(0, 1, 16'hFFFF, 0);
        cyc(0, 1, 16'h0001, 0);
        for (int i = 0; i < SAMPLES - 1; i++) cyc(0, 1, 16'($urandom), 0);
        cyc(0, 0, 16'h0, 0);
    endtask

    task automatic test_reset();
        logic [19:0] outs;
        for (int i = 0; i < 3; i++) begin
            cyc(1, i[0], 16'($urandom), 0);
            outs = {wr_en, wr_addr, wr_data, read_bank, capturing};
            checks++;
            if (outs !== 20'h0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, outs);
            end
        end
        cyc(0, 0, 16'h0, 0);
    endtask

    task automatic test_zero_cross();
        int n_wr = 0, first_i = -1, cap_bad = 0;
        logic [8:0] first_addr = 0, last_addr = 0;
        logic [7:0] first_data = 0;
        logic [15:0] s;
        do_reset();
        for (int i = 0; i < 258; i++) begin
            case (i)
                0:       s = 16'hFF9C;
                1:       s = 16'hFFFF;
                2:       s = 16'h0005;
                default: s = 16'($urandom);
            endcase
            cyc(0, 1, s, 0);
            if (wr_en) begin
                if (n_wr == 0) begin first_i = i; first_addr = wr_addr; first_data = wr_data; end
                last_addr = wr_addr;
                n_wr++;
                if (n_wr < SAMPLES && capturing !== 1'b1) cap_bad++;
            end else if (capturing !== 1'b0) begin
                cap_bad++;
            end
        end
        cyc(0, 0, 16'h0, 0);
        checks++; if (n_wr != 256) begin failures++; $display("FAIL zc_count: got %0d expected 256", n_wr); end
        checks++; if (first_i != 2) begin failures++; $display("FAIL zc_first_cycle: got %0d expected 2", first_i); end
        checks++; if (first_addr !== 9'h100) begin failures++; $display("FAIL zc_first_addr: got %h expected 100", first_addr); end
        checks++; if (first_data !== 8'h80) begin failures++; $display("FAIL zc_first_data: got %h expected 80", first_data); end
        checks++; if (last_addr !== 9'h1FF) begin failures++; $display("FAIL zc_last_addr: got %h expected 1ff", last_addr); end
        checks++; if (cap_bad != 0) begin failures++; $display("FAIL zc_capturing: got %0d bad cycles expected 0", cap_bad); end
        checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL zc_cap_after: got %b expected 0", capturing); end
    endtask

    task automatic test_timeout();
        int first_p = -1;
        logic [8:0] a = 0;
        logic [7:0] d = 0;
        do_reset();
        for (int p = 1; p <= TIMEOUT; p++) begin
            cyc(0, 1, 16'h1234, 0);
            if (wr_en && first_p < 0) begin first_p = p; a = wr_addr; d = wr_data; end
            cyc(0, 0, 16'h1234, 0);
        end
        checks++; if (first_p != 1024) begin failures++; $display("FAIL tmo_pulse: got %0d expected 1024", first_p); end
        checks++; if (a !== 9'h100) begin failures++; $display("FAIL tmo_addr: got %h expected 100", a); end
        checks++; if (d !== 8'h92) begin failures++; $display("FAIL tmo_data: got %h expected 92", d); end
        checks++; if (capturing !== 1'b1) begin failures++; $display("FAIL tmo_capturing: got %b expected 1", capturing); end
    endtask

    task automatic test_swap();
        int bad = 0;
        do_reset();
        cyc(0, 1, 16'hFFFF, 0);
        cyc(0, 1, 16'h0001, 0);
        for (int i = 0; i < SAMPLES - 1; i++) begin
            cyc(0, 1, 16'($urandom), (i < 200) && (i % 8 < 3));
            if (read_bank !== 1'b0) bad++;
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 16'h0, 0);
            if (read_bank !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL swap_during_capture: got %0d bad cycles expected 0", bad); end
        cyc(0, 0, 16'h0, 1);
        checks++; if (read_bank !== 1'b0) begin failures++; $display("FAIL swap_1cyc: got %b expected 0", read_bank); end
        cyc(0, 0, 16'h0, 1);
        checks++; if (read_bank !== 1'b1) begin failures++; $display("FAIL swap_2cyc: got %b expected 1", read_bank); end
        cyc(0, 0, 16'h0, 0);
        cyc(0, 1, 16'hFFFF, 0);
        cyc(0, 1, 16'h0001, 0);
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL swap_next_wr: got %b expected 1", wr_en); end
        checks++; if (wr_addr !== 9'h000) begin failures++; $display("FAIL swap_next_addr: got %h expected 000", wr_addr); end
    endtask

    task automatic test_final_write_rise();
        int bad = 0;
        do_reset();
        cyc(0, 1, 16'hFFFF, 0);
        cyc(0, 1, 16'h0001, 0);
        for (int i = 0; i < SAMPLES - 3; i++) cyc(0, 1, 16'($urandom), 0);
        cyc(0, 1, 16'($urandom), 1);
        cyc(0, 1, 16'($urandom), 1);
        checks++; if (wr_addr !== 9'h1FF) begin failures++; $display("FAIL fwr_last_addr: got %h expected 1ff", wr_addr); end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 16'h0, 1);
            if (read_bank !== 1'b0 || capturing !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL fwr_no_swap: got %0d bad cycles expected 0", bad); end
        cyc(0, 0, 16'h0, 0);
        cyc(0, 0, 16'h0, 1);
        cyc(0, 0, 16'h0, 1);
        checks++; if (read_bank !== 1'b1) begin failures++; $display("FAIL fwr_next_swap: got %b expected 1", read_bank); end
    endtask

    task automatic test_coincident();
        do_reset();
        run_window();
        cyc(0, 1, 16'hFFFB, 0);
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL co_done_ignored: got %b expected 0", wr_en); end
        cyc(0, 0, 16'h0, 1);
        cyc(0, 1, 16'h0007, 1);
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL co_no_wr: got %b expected 0", wr_en); end
        checks++; if (read_bank !== 1'b1) begin failures++; $display("FAIL co_swap: got %b expected 1", read_bank); end
        checks++; if (capturing !== 1'b0) begin failures++; $display("FAIL co_capturing: got %b expected 0", capturing); end
        cyc(0, 1, 16'hFFFE, 0);
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL co_armed_idle: got %b expected 0", wr_en); end
        cyc(0, 1, 16'h0009, 0);
        checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 9'h000, 8'h80}) begin
            failures++; $display("FAIL co_retrigger: got %b/%h/%h expected 1/000/80", wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_window();
        cyc(0, 0, 16'h0, 1);
        cyc(0, 0, 16'h0, 1);
        cyc(0, 0, 16'h0, 0);
        checks++; if (read_bank !== 1'b1) begin failures++; $display("FAIL rm_pre_bank: got %b expected 1", read_bank); end
        cyc(0, 1, 16'hFFFF, 0);
        cyc(0, 1, 16'h0001, 0);
        for (int i = 0; i < 99; i++) cyc(0, 1, 16'($urandom), 0);
        checks++; if (wr_addr !== 9'h063) begin failures++; $display("FAIL rm_idx99: got %h expected 063", wr_addr); end
        cyc(1, 1, 16'($urandom), 0);
        checks++; if ({wr_en, read_bank, capturing} !== 3'b000) begin
            failures++; $display("FAIL rm_reset_outs: got %b expected 000", {wr_en, read_bank, capturing});
        end
        cyc(1, 1, 16'($urandom), 0);
        cyc(0, 0, 16'h0, 0);
        cyc(0, 1, 16'h0003, 0);
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rm_no_trigger: got %b expected 0", wr_en); end
        cyc(0, 1, 16'hFFFF, 0);
        cyc(0, 1, 16'h0001, 0);
        checks++; if ({wr_en, wr_addr} !== {1'b1, 9'h100}) begin
            failures++; $display("FAIL rm_restart: got %b/%h expected 1/100", wr_en, wr_addr);
        end
    endtask

    task automatic test_random();
        bit vs = 0;
        bit rst, ns;
        logic [15:0] s;
        int errs = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 1499) == 0);
            ns  = ($urandom_range(0, 3) != 0);
            s   = 16'($urandom);
            if ($urandom_range(0, 39) == 0) vs = !vs;
            cyc(rst, ns, s, vs);
            checks++;
            if (wr_en !== e_wr_en) begin
                failures++; errs++;
                if (errs < 20) $display("FAIL rnd_wr_en cycle %0d: got %b expected %b", c, wr_en, e_wr_en);
                else $display("FAIL rnd_wr_en");
            end
            if (e_wr_en) begin
                checks++;
                if ({wr_addr, wr_data} !== {e_addr, e_data}) begin
                    failures++;
                    $display("FAIL rnd_wr_word cycle %0d: got %h/%h expected %h/%h", c, wr_addr, wr_data, e_addr, e_data);
                end
            end
            checks++;
            if ({read_bank, capturing} !== {m_rb, e_cap}) begin
                failures++;
                $display("FAIL rnd_bank_cap cycle %0d: got %b%b expected %b%b", c, read_bank, capturing, m_rb, e_cap);
            end
        end
    endtask

    initial begin
        reset = 1'b1; new_sample = 1'b0; sample = 16'h0; vsync = 1'b0;
        test_reset();
        test_zero_cross();
        test_timeout();
        test_swap();
        test_final_write_rise();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
